// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction-memory addressing and the IF/ID output buffer.
// Optional macro FETCH_BOUNDS_CHECK_EN enables sticky fault on bad redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic [31:0] fetch_count,
   output logic        fault
);

   localparam logic [31:0] AMASK = 32'(MEM_BYTES - 1);
   localparam logic [31:0] LAST  = 32'(MEM_BYTES - 4);

   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] opc_q, opc_d;
   logic [31:0] opc4_q, opc4_d;
   logic [31:0] cnt_q, cnt_d;
   logic        fault_q;
   logic        bad;
   logic        redir;
   logic        accept;
   logic        cap;
   logic [31:0] next_pc;
   logic [31:0] target;

`ifdef FETCH_BOUNDS_CHECK_EN
   logic fault_d;

   assign bad     = (redirect_pc[1:0] != 2'b00) | (redirect_pc > LAST);
   assign fault_d = fault_q | (redirect_valid & bad);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end
`else
   assign bad     = 1'b0;
   assign fault_q = 1'b0;
`endif

   assign next_pc = (pc_q + 32'd4) & AMASK;
   assign target  = redirect_pc & AMASK & ~32'h3;
   assign accept  = valid_q & out_ready;
   // A latched fault freezes the stage, so later redirects are ignored
   assign redir   = redirect_valid & !fault_q;
   assign cap     = !halt & !fault_q & !redirect_valid
                  & (!valid_q | out_ready);

   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      inst_d  = inst_q;
      opc_d   = opc_q;
      opc4_d  = opc4_q;
      cnt_d   = cnt_q + {31'd0, accept};
      if (redir) begin
         valid_d = 1'b0;
         if (!bad) pc_d = target;
      end else if (cap) begin
         inst_d  = imem_data;
         opc_d   = pc_q;
         opc4_d  = next_pc;
         valid_d = 1'b1;
         pc_d    = next_pc;
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         inst_q  <= 32'd0;
         opc_q   <= 32'd0;
         opc4_q  <= 32'd0;
         cnt_q   <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         opc_q   <= opc_d;
         opc4_q  <= opc4_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr    = pc_q;
   assign out_valid    = valid_q;
   assign out_inst     = inst_q;
   assign out_pc       = opc_q;
   assign out_pc_plus4 = opc4_q;
   assign fetch_count  = cnt_q;
   assign fault        = fault_q;

endmodule
